// File: rtl/sp_ram_requester.sv
// Request/response front end for a single-port, synchronous-read RAM.
// Reads are returned in order through a 2-entry buffer guarded by a credit check.
module sp_ram_requester #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [2];

    logic             fire;
    logic             pop;
    logic             capture;
    logic [OCC_W-1:0] occ;

    // Credit: buffered + in-flight reads, minus the entry leaving this cycle.
    always_comb begin
        occ       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        req_ready = rst_n & (occ < OCC_W'(2));
    end

    assign fire      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign capture   = inflight_q;

    assign ram_we    = fire & req_we;
    assign ram_addr  = req_addr;
    assign ram_din   = req_wdata;

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = mem_q[rd_ptr_q];

    always_comb begin
        inflight_d = fire & ~req_we;
        count_d    = count_q + CNT_W'(capture) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q ^ capture;
        rd_ptr_d   = rd_ptr_q ^ pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            mem_q[wr_ptr_q] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_sp_ram_requester.sv
// Scoreboard bench for sp_ram_requester with a behavioural synchronous-read RAM.
module tb_sp_ram_requester;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [16];
    logic [7:0] sb_q [$];
    int         pop_cyc [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;

    sp_ram_requester #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_vec++;
            pop_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got %0h, expected no response (cycle %0d)", rsp_rdata, cyc);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (rsp_rdata !== e) begin
                    n_err++;
                    $display("FAIL rsp_data: got %0h, expected %0h (cycle %0d)", rsp_rdata, e, cyc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the firing edge.
    task automatic req(input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] exp, output int waits, output int fcyc);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        waits     = 0;
        fcyc      = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                if (!we) sb_q.push_back(exp);
                chk("ram_we_at_fire", 32'(ram_we), 32'(we));
                fcyc = cyc;
                @(posedge clk); #1;
                break;
            end
            waits++;
        end
        if (fcyc < 0) chk("req_timeout", 0, 1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb_q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("no_extra_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, f, first;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h0;
        req_wdata = 8'hEE;

        // Reset with a write request pending.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 1);
        chk("post_rst_ram_we", 32'(ram_we), 1);
        @(posedge clk); #1;
        idle();

        // Write then read same address on consecutive cycles.
        rsp_ready = 1'b1;
        req(1'b1, 4'd3, 8'hA5, 8'h00, w, f);
        req(1'b0, 4'd3, 8'h00, 8'hA5, w, f);
        idle();
        @(negedge clk);
        chk("lat_n1_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n2_valid", 32'(rsp_valid), 1);
        chk("lat_n2_data", 32'(rsp_rdata), 32'h A5);
        @(posedge clk); #1;
        drain();
        quiet(4);

        // Preload then stream 16 back-to-back reads.
        for (int k = 0; k < 16; k++) begin
            req(1'b1, 4'(k), 8'(k * 8'h11), 8'h00, w, f);
            chk("preload_wait", 32'(w), 0);
        end
        pop_cyc.delete();
        first = -1;
        for (int k = 0; k < 16; k++) begin
            req(1'b0, 4'(k), 8'h00, 8'(k * 8'h11), w, f);
            chk("stream_ready", 32'(w), 0);
            if (k == 0) first = f;
        end
        idle();
        drain();
        chk("stream_count", 32'(pop_cyc.size()), 16);
        for (int k = 0; k < 16 && k < pop_cyc.size(); k++)
            chk("stream_contig", 32'(pop_cyc[k]), 32'(first + 2 + k));

        // Backpressure: third read must wait for a pop.
        rsp_ready = 1'b0;
        req(1'b0, 4'd1, 8'h00, 8'h11, w, f);
        req(1'b0, 4'd2, 8'h00, 8'h22, w, f);
        chk("bp_second_wait", 32'(w), 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(req_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_data_stable", 32'(rsp_rdata), 32'h11);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        req(1'b0, 4'd3, 8'h00, 8'h33, w, f);
        chk("bp_third_wait", 32'(w), 0);
        idle();
        drain();
        quiet(3);

        // Simultaneous capture and pop with rsp_ready toggling; count starts at 1.
        rsp_ready = 1'b0;
        req(1'b0, 4'd4, 8'h00, 8'h44, w, f);
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        chk("sim_count1", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rsp_ready = ~rsp_ready;
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    req(1'b0, 4'((5 + i) % 16), 8'h00, 8'(((5 + i) % 16) * 8'h11), w, f);
                end
                idle();
            end
        join
        rsp_ready = 1'b1;
        drain();
        quiet(3);

        // Reset one cycle after a read fire with one entry buffered.
        rsp_ready = 1'b0;
        req(1'b1, 4'd2, 8'h5A, 8'h00, w, f);
        req(1'b0, 4'd5, 8'h00, 8'h55, w, f);
        idle();
        @(posedge clk); #1;
        req(1'b0, 4'd6, 8'h00, 8'h66, w, f);
        rst_n     = 1'b0;
        sb_q.delete();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd2;
        req_wdata = 8'hFF;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_ram_we", 32'(ram_we), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        idle();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        quiet(6);
        req(1'b0, 4'd2, 8'h00, 8'h5A, w, f);
        idle();
        drain();
        quiet(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
